sdram_rom_arbiter: RTL and testbench

- Shares the SDRAM controller's single ROM toggle-handshake port between three requesters: 0 = ioctl download, 1 = CPU ROM fetch, 2 = cheat/patch engine.
- Arbitration is round-robin, one transaction in flight at a time.
- The block latches address, data and direction for the granted request and reissues it as one downstream toggle request.
- It returns read data after a fixed controller read latency, then toggles the requester's ack.

---
 rtl/sdram_rom_arbiter_pkg.sv | 19 +
 rtl/sdram_rom_arbiter_if.sv | 44 ++++
 rtl/sdram_rom_arbiter_rr_pick3.sv | 28 ++
 rtl/sdram_rom_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_rom_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_rom_arbiter_pkg.sv
// Shared constants and types for the three-port SDRAM ROM arbiter.
// Port indices, the controller read latency default and the FSM state set.
package sdram_arb_pkg;

  localparam int NPORT              = 3;
  localparam int READ_DELAY_DEFAULT = 5;

  localparam logic [1:0] PORT_IOCTL = 2'd0;
  localparam logic [1:0] PORT_CPU   = 2'd1;
  localparam logic [1:0] PORT_CHEAT = 2'd2;

  typedef enum logic [1:0] {
    ST_ALIGN     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DATA = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_rom_arbiter_if.sv
// Requester-side and controller-side signals of the ROM arbiter.
// Handshake: every port uses toggle semantics; a request is pending while
// req != ack, and the responder completes it by making ack equal to req.
interface sdram_rom_arbiter_if;

  logic        p0_req,  p1_req,  p2_req;
  logic        p0_ack,  p1_ack,  p2_ack;
  logic [22:0] p0_addr, p1_addr, p2_addr;
  logic [15:0] p0_din,  p1_din,  p2_din;
  logic        p0_we,   p1_we,   p2_we;
  logic [15:0] p0_dout, p1_dout, p2_dout;

  logic        rom_req;
  logic        rom_req_ack;
  logic [22:0] rom_addr;
  logic [15:0] rom_din;
  logic        rom_we;
  logic [15:0] rom_dout;

  // Arbiter view.
  modport slave (
    input  p0_req, p1_req, p2_req,
    input  p0_addr, p1_addr, p2_addr,
    input  p0_din, p1_din, p2_din,
    input  p0_we, p1_we, p2_we,
    output p0_ack, p1_ack, p2_ack,
    output p0_dout, p1_dout, p2_dout,
    output rom_req, rom_addr, rom_din, rom_we,
    input  rom_req_ack, rom_dout
  );

  // Requesters plus controller view.
  modport master (
    output p0_req, p1_req, p2_req,
    output p0_addr, p1_addr, p2_addr,
    output p0_din, p1_din, p2_din,
    output p0_we, p1_we, p2_we,
    input  p0_ack, p1_ack, p2_ack,
    input  p0_dout, p1_dout, p2_dout,
    input  rom_req, rom_addr, rom_din, rom_we,
    output rom_req_ack, rom_dout
  );

endinterface

// File: rtl/sdram_rom_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Scans from (ptr+1) mod 3 and wraps; ptr = 3 is treated like 2.
module rr_pick3 (
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    case (ptr)
      2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase

    found = |pending;
    idx   = c2;
    if (pending[c0])      idx = c0;
    else if (pending[c1]) idx = c1;
  end

endmodule

// File: rtl/sdram_rom_arbiter.sv
// Shares the SDRAM controller's toggle-handshake ROM port between three
// requesters, one transaction in flight, round-robin between pending ports.
module sdram_rom_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int READ_DELAY = READ_DELAY_DEFAULT
) (
  input  logic                clk,
  input  logic                init_n,
  sdram_rom_arbiter_if.slave  bus,
  output logic                busy,
  output logic [1:0]          grant,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_ALIGN     = ST_ALIGN;
  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_WAIT_ACK  = ST_WAIT_ACK;
  localparam logic [1:0] S_WAIT_DATA = ST_WAIT_DATA;

  localparam logic [2:0] CNT_LOAD = 3'(READ_DELAY - 1);

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [2:0]       cnt;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] ack_q;
  logic [NPORT-1:0] pending;
  logic [15:0]      dout_q [NPORT];
  logic             rom_req_q;
  logic [22:0]      rom_addr_q;
  logic [15:0]      rom_din_q;
  logic             rom_we_q;
  logic             found;
  logic [1:0]       pick;
  logic [22:0]      sel_addr;
  logic [15:0]      sel_din;
  logic             sel_we;

  assign req     = {bus.p2_req, bus.p1_req, bus.p0_req};
  assign pending = req ^ ack_q;

  rr_pick3 u_pick (
    .pending (pending),
    .ptr     (ptr),
    .found   (found),
    .idx     (pick)
  );

  always_comb begin
    sel_addr = bus.p2_addr;
    sel_din  = bus.p2_din;
    sel_we   = bus.p2_we;
    case (pick)
      PORT_IOCTL: begin sel_addr = bus.p0_addr; sel_din = bus.p0_din; sel_we = bus.p0_we; end
      PORT_CPU:   begin sel_addr = bus.p1_addr; sel_din = bus.p1_din; sel_we = bus.p1_we; end
      default:    begin sel_addr = bus.p2_addr; sel_din = bus.p2_din; sel_we = bus.p2_we; end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= S_ALIGN;
      ptr        <= PORT_CHEAT;
      grant      <= PORT_CHEAT;
      cnt        <= 3'd0;
      ack_q      <= '0;
      dout_q[0]  <= 16'd0;
      dout_q[1]  <= 16'd0;
      dout_q[2]  <= 16'd0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= 23'd0;
      rom_din_q  <= 16'd0;
      rom_we_q   <= 1'b0;
    end else begin
      case (state)
        // Adopt the controller's ack level so no request is implied at start.
        S_ALIGN: begin
          rom_req_q <= bus.rom_req_ack;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          if (found) begin
            rom_addr_q <= sel_addr;
            rom_din_q  <= sel_din;
            rom_we_q   <= sel_we;
            rom_req_q  <= ~rom_req_q;
            grant      <= pick;
            ptr        <= pick;
            state      <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (bus.rom_req_ack == rom_req_q) begin
            if (rom_we_q) begin
              ack_q[grant] <= req[grant];
              state        <= S_IDLE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          // Controller data is valid READ_DELAY cycles after the ack match.
          if (cnt == 3'd0) begin
            dout_q[grant] <= bus.rom_dout;
            ack_q[grant]  <= req[grant];
            state         <= S_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p0_ack   = ack_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p2_ack   = ack_q[2];
  assign bus.p0_dout  = dout_q[0];
  assign bus.p1_dout  = dout_q[1];
  assign bus.p2_dout  = dout_q[2];
  assign bus.rom_req  = rom_req_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_din  = rom_din_q;
  assign bus.rom_we   = rom_we_q;
  assign busy         = (state != S_IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Directed and randomized bench for sdram_rom_arbiter; the bench plays all
// three requesters and the SDRAM controller, checking against a port model.
module tb_sdram_rom_arbiter;
  import sdram_arb_pkg::*;

  localparam int RD = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic init_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  sdram_rom_arbiter_if bus();
  logic       busy;
  logic [1:0] grant;
  logic [1:0] state_dbg;

  sdram_rom_arbiter #(.READ_DELAY(RD)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .bus       (bus),
    .busy      (busy),
    .grant     (grant),
    .state_dbg (state_dbg)
  );

  logic [2:0]  req_v;
  logic [22:0] addr_v [3];
  logic [15:0] din_v  [3];
  logic [2:0]  we_v;
  logic        rom_req_ack;
  logic [15:0] rom_dout;
  logic [2:0]  ack_o;
  logic [15:0] dout_o [3];

  assign bus.p0_req = req_v[0];
  assign bus.p1_req = req_v[1];
  assign bus.p2_req = req_v[2];
  assign bus.p0_addr = addr_v[0];
  assign bus.p1_addr = addr_v[1];
  assign bus.p2_addr = addr_v[2];
  assign bus.p0_din = din_v[0];
  assign bus.p1_din = din_v[1];
  assign bus.p2_din = din_v[2];
  assign bus.p0_we = we_v[0];
  assign bus.p1_we = we_v[1];
  assign bus.p2_we = we_v[2];
  assign bus.rom_req_ack = rom_req_ack;
  assign bus.rom_dout = rom_dout;
  assign ack_o = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
  assign dout_o[0] = bus.p0_dout;
  assign dout_o[1] = bus.p1_dout;
  assign dout_o[2] = bus.p2_dout;

  // ---------------- reference model / scoreboard ----------------
  int          errors;
  int          checks;
  logic [2:0]  exp_ack;
  logic [15:0] exp_dout [3];
  int          mptr;
  logic [22:0] q_addr [3];
  logic [15:0] q_din  [3];
  logic        q_we   [3];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next port to be served: first pending one after the last grant, wrapping.
  function automatic int next_grant();
    for (int k = 1; k <= 3; k++) begin
      if (req_v[(mptr + k) % 3] != exp_ack[(mptr + k) % 3]) return (mptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic chk_ports(input string tag);
    chk({tag, "_acks"}, 32'(ack_o), 32'(exp_ack));
    for (int i = 0; i < 3; i++) chk($sformatf("%s_dout%0d", tag, i), 32'(dout_o[i]), 32'(exp_dout[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int p, input logic we, input logic [22:0] a, input logic [15:0] d);
    addr_v[p] = a;
    din_v[p]  = d;
    we_v[p]   = we;
    q_addr[p] = a;
    q_din[p]  = d;
    q_we[p]   = we;
    req_v[p]  = ~req_v[p];
  endtask

  task automatic do_reset(input logic ack_lvl);
    @(negedge clk);
    init_n      = 1'b0;
    req_v       = '0;
    we_v        = '0;
    rom_req_ack = ack_lvl;
    rom_dout    = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      din_v[i]  = '0;
      exp_dout[i] = '0;
    end
    exp_ack = '0;
    mptr    = 2;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk_ports("rst");
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_grant", 32'(grant), 32'(2));
    chk("rst_rom_req", 32'(bus.rom_req), 32'(0));
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
    chk("rst_rom_din", 32'(bus.rom_din), 32'(0));
    chk("rst_rom_we", 32'(bus.rom_we), 32'(0));
    init_n = 1'b1;
    @(negedge clk);
    chk("align_busy", 32'(busy), 32'(0));
    chk("align_rom_req", 32'(bus.rom_req), 32'(ack_lvl));
  endtask

  // Acts as the controller for one transaction: waits for the downstream
  // request, acks after dly cycles, and returns rd for reads.
  task automatic serve(input int dly, input logic [15:0] rd, output int g_obs);
    int   g;
    int   t;
    logic rwe;
    g     = next_grant();
    g_obs = -1;
    t     = 0;
    while (bus.rom_req === rom_req_ack && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("issue_seen", 32'(t < 20), 32'(1));
    if (t >= 20) return;
    g_obs = int'(grant);
    chk("grant", 32'(grant), 32'(g));
    if (g < 0) return;
    chk("rom_addr", 32'(bus.rom_addr), 32'(q_addr[g]));
    chk("rom_din", 32'(bus.rom_din), 32'(q_din[g]));
    chk("rom_we", 32'(bus.rom_we), 32'(q_we[g]));
    rwe  = q_we[g];
    mptr = g;
    addr_v[g] = 23'($urandom);
    din_v[g]  = 16'($urandom);
    we_v[g]   = ~we_v[g];
    repeat (dly) begin
      @(negedge clk);
      chk("wait_ack_busy", 32'(busy), 32'(1));
      chk("wait_ack_acks", 32'(ack_o), 32'(exp_ack));
    end
    rom_req_ack = bus.rom_req;
    if (rwe) begin
      @(negedge clk);
      exp_ack[g] = req_v[g];
      chk_ports("wr_done");
      chk("wr_busy", 32'(busy), 32'(0));
      chk("wr_addr_held", 32'(bus.rom_addr), 32'(q_addr[g]));
    end else begin
      exp_q.push_back(rd);
      repeat (RD) begin
        rom_dout = ~rd;
        @(negedge clk);
        chk("rd_wait_acks", 32'(ack_o), 32'(exp_ack));
      end
      rom_dout = rd;
      @(negedge clk);
      rom_dout    = ~rd;
      exp_ack[g]  = req_v[g];
      exp_dout[g] = exp_q.pop_front();
      chk_ports("rd_done");
      chk("rd_busy", 32'(busy), 32'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int guard;
    int order [4];
    errors = 0;
    checks = 0;
    init_n = 1'b1;
    req_v  = '0;
    we_v   = '0;
    rom_req_ack = 1'b0;
    rom_dout    = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      din_v[i]  = '0;
    end

    // Reset with controller ack high, then idle with no requests.
    do_reset(1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("idle_rom_req", 32'(bus.rom_req), 32'(1));
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // Single read on the CPU port.
    issue(1, 1'b0, 23'h001234, 16'h0000);
    @(negedge clk);
    chk("issue_lat1", 32'(bus.rom_req ^ rom_req_ack), 32'(1));
    serve(3, 16'hBEEF, g);
    chk("p1_dout", 32'(dout_o[1]), 32'hBEEF);

    // Write on the download port.
    issue(0, 1'b1, 23'h400000, 16'hA55A);
    serve(2, 16'h0000, g);
    chk("p0_dout_after_wr", 32'(dout_o[0]), 32'(0));

    // All three pending from reset, p1 re-requests while p2 waits.
    do_reset(1'b0);
    issue(0, 1'b0, 23'h000010, 16'h0);
    issue(1, 1'b0, 23'h000020, 16'h0);
    issue(2, 1'b1, 23'h000030, 16'h1111);
    serve(1, 16'h1001, order[0]);
    serve(0, 16'h2002, order[1]);
    issue(1, 1'b1, 23'h000040, 16'h2222);
    serve(2, 16'h3003, order[2]);
    serve(1, 16'h4004, order[3]);
    chk("order0", 32'(order[0]), 32'(0));
    chk("order1", 32'(order[1]), 32'(1));
    chk("order2", 32'(order[2]), 32'(2));
    chk("order3", 32'(order[3]), 32'(1));

    // Reset pulse while a read is waiting for data.
    do_reset(1'b0);
    issue(2, 1'b0, 23'h7ABCDE, 16'h0);
    @(negedge clk);
    chk("rst_mid_issue", 32'(bus.rom_req ^ rom_req_ack), 32'(1));
    rom_req_ack = bus.rom_req;
    repeat (3) @(negedge clk);
    rom_dout = 16'hDEAD;
    chk("rst_mid_busy", 32'(busy), 32'(1));
    init_n = 1'b0;
    #1;
    chk_ports("rst_mid");
    chk("rst_mid_rom_req", 32'(bus.rom_req), 32'(0));
    @(negedge clk);
    init_n  = 1'b1;
    exp_ack = '0;
    mptr    = 2;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_align", 32'(bus.rom_req), 32'(rom_req_ack));
    serve(1, 16'h5AA5, g);
    chk("rst_mid_regrant", 32'(g), 32'(2));
    chk("rst_mid_dout", 32'(dout_o[2]), 32'h5AA5);

    // Long controller stall.
    issue(0, 1'b0, 23'h0000FF, 16'h0);
    serve(40, 16'h7777, g);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 3; p++) begin
        if (req_v[p] == exp_ack[p] && $urandom_range(0, 1) == 1)
          issue(p, 1'($urandom_range(0, 1)), 23'($urandom), 16'($urandom));
      end
      if (next_grant() < 0)
        issue(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 23'($urandom), 16'($urandom));
      serve(int'($urandom_range(0, 6)), 16'($urandom), g);
    end
    guard = 0;
    while (next_grant() >= 0 && guard < 5) begin
      serve(int'($urandom_range(0, 3)), 16'($urandom), g);
      guard++;
    end
    chk("drained", 32'(ack_o), 32'(req_v));

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
